dragon_length_ctrl: RTL and testbench
=====================================

// Module: dragon_length_ctrl
//
// PURPOSE
//   Generates the single-cycle lengthUpdate command consumed by the dragon body
//   segment queue (HEAL grows it by one segment, HIT shrinks it by one).
//   Turns level-type hit/heal requests from the collision logic into clean pulses.
//   Keeps a shadow copy of the displayed body length, enforces post-hit
//   invulnerability counted in frames, and flags game over.
//   Sits between collision detection and the dragon body; driven by clk/vsync.
//
// PARAMETERS
//   MAX_LEN              7   max body segments; must match body queue depth
//   HIT_COOLDOWN_FRAMES  60  vsync rising edges of invulnerability after a HIT
//
// PORTS
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-low
//   vsync         in   1  frame sync level; its rising edge = one frame tick
//   hit_req       in   1  level from collision logic; rising edge = hit event
//   heal_req      in   1  level from collision logic; rising edge = heal event
//   lengthUpdate  out  2  00 MOVE, 01 HEAL, 10 HIT; 11 never driven
//   length        out  3  shadow count of enabled body segments, 0..MAX_LEN
//   invuln        out  1  high while the hit cooldown is running
//   game_over     out  1  sticky; set on a hit taken at length 0
//
// BEHAVIOUR
//   Reset (reset==0 at a clk edge):
//   - lengthUpdate=00, length=0, invuln=0, game_over=0.
//   - Clears pending flags, edge registers and cooldown counter; FSM -> IDLE.
//   - Reset mid-pulse or mid-cooldown aborts it. The next cycle drives 00.
//   Edge detect:
//   - hit_req, heal_req and vsync are each registered once.
//   - Event = input high AND its registered copy low. Held levels give one event.
//   Pending latches (hit_pend, heal_pend):
//   - Set the cycle after an event. Cleared when the FSM consumes them.
//   - A new event while already pending is merged, not counted twice.
//   - A hit event while invuln==1 is dropped (never pended).
//   FSM: IDLE, PULSE, DEAD.
//   - IDLE, hit_pend, length>0: drive HIT next cycle, length-1, load cooldown
//     counter with HIT_COOLDOWN_FRAMES, clear hit_pend AND heal_pend, go PULSE.
//     Hit wins; a simultaneous heal is discarded.
//   - IDLE, hit_pend, length==0: game_over<=1, no pulse, go DEAD.
//   - IDLE, heal_pend only, length<MAX_LEN: drive HEAL next cycle, length+1,
//     clear heal_pend, go PULSE.
//   - IDLE, heal_pend only, length==MAX_LEN: clear heal_pend, no pulse, stay IDLE.
//   - PULSE: lengthUpdate<=00 (pulse width exactly 1 clk), go IDLE.
//     Pending flags may still set in PULSE; they are served from IDLE.
//   - DEAD: lengthUpdate held 00. All events ignored. Exit only via reset.
//   Latency:
//   - First cycle a request is sampled high = n. Pulse is high in cycle n+2.
//   - Minimum spacing between consecutive pulses = 2 clk.
//   Cooldown:
//   - Counter width = $clog2(HIT_COOLDOWN_FRAMES+1).
//   - Decrements on each vsync rising edge while nonzero; holds at 0.
//   - invuln = (counter != 0), registered.
//   - Heal is allowed during cooldown.
//   Invariant: length always equals the popcount of the body Display_en.
//
// TESTING
//   1 Reset: hold reset=0 for 3 clk, then release -> lengthUpdate=00, length=0,
//     invuln=0, game_over=0.
//   2 heal_req high 5 clk -> exactly one 01 pulse, 1 clk wide, 2 clk after the
//     first high sample; length=1.
//   3 Eight separated heal edges -> seven 01 pulses; length saturates at 7;
//     8th edge produces no pulse.
//   4 Length 3, hit edge -> one 10 pulse, length=2, invuln=1.
//     Hit edge after 30 vsync edges -> no pulse.
//     After 60 vsync edges invuln=0; next hit edge -> 10 pulse, length=1.
//   5 Length 2, hit_req and heal_req rise in the same clk -> single 10 pulse,
//     length=1, no 01 pulse afterwards.
//   6 Length 0, invuln=0, hit edge -> game_over=1 two clk later, no pulse;
//     later heal edges ignored. Reset -> game_over=0, length=0.

Source files
------------

// File: rtl/dragon_length_ctrl.sv
// Dragon body length controller: turns hit/heal request levels into
// one-clock lengthUpdate pulses, tracks length, invulnerability and game over.
module dragon_length_ctrl #(
   parameter int MAX_LEN             = 7,
   parameter int HIT_COOLDOWN_FRAMES = 60
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         vsync,
   input  logic                         hit_req,
   input  logic                         heal_req,
   output logic [1:0]                   lengthUpdate,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic                         invuln,
   output logic                         game_over
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int CW = $clog2(HIT_COOLDOWN_FRAMES + 1);

   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
   localparam logic [LW-1:0] LEN_ONE  = LW'(1);
   localparam logic [CW-1:0] COOL_LD  = CW'(HIT_COOLDOWN_FRAMES);
   localparam logic [CW-1:0] COOL_ONE = CW'(1);

   localparam logic [1:0] UPD_MOVE = 2'b00;
   localparam logic [1:0] UPD_HEAL = 2'b01;
   localparam logic [1:0] UPD_HIT  = 2'b10;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_PULSE = 2'b01;
   localparam logic [1:0] S_DEAD  = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [1:0]    upd_q, upd_d;
   logic [LW-1:0] len_q, len_d;
   logic [CW-1:0] cool_q, cool_d;
   logic          invuln_q, invuln_d;
   logic          over_q, over_d;
   logic          hit_pend_q, hit_pend_d;
   logic          heal_pend_q, heal_pend_d;
   logic          hit_r_q, heal_r_q, vs_r_q;

   logic hit_evt, heal_evt, vs_evt;

   assign hit_evt  = hit_req & ~hit_r_q;
   assign heal_evt = heal_req & ~heal_r_q;
   assign vs_evt   = vsync & ~vs_r_q;

   always_comb begin
      state_d     = state_q;
      upd_d       = upd_q;
      len_d       = len_q;
      cool_d      = cool_q;
      over_d      = over_q;
      hit_pend_d  = hit_pend_q;
      heal_pend_d = heal_pend_q;

      if (vs_evt && cool_q != '0) begin
         cool_d = cool_q - COOL_ONE;
      end

      unique case (state_q)
         S_IDLE: begin
            upd_d = UPD_MOVE;
            if (hit_pend_q) begin
               hit_pend_d  = 1'b0;
               heal_pend_d = 1'b0;
               if (len_q != '0) begin
                  upd_d   = UPD_HIT;
                  len_d   = len_q - LEN_ONE;
                  cool_d  = COOL_LD;
                  state_d = S_PULSE;
               end else begin
                  over_d  = 1'b1;
                  state_d = S_DEAD;
               end
            end else if (heal_pend_q) begin
               heal_pend_d = 1'b0;
               if (len_q < LEN_MAX) begin
                  upd_d   = UPD_HEAL;
                  len_d   = len_q + LEN_ONE;
                  state_d = S_PULSE;
               end
            end
         end
         S_PULSE: begin
            upd_d   = UPD_MOVE;
            state_d = S_IDLE;
         end
         S_DEAD: begin
            upd_d       = UPD_MOVE;
            hit_pend_d  = 1'b0;
            heal_pend_d = 1'b0;
         end
         default: begin
            upd_d   = UPD_MOVE;
            state_d = S_IDLE;
         end
      endcase

      // A fresh event wins over the consume-clear so it is never lost.
      if (state_q != S_DEAD) begin
         if (hit_evt && !invuln_q) hit_pend_d = 1'b1;
         if (heal_evt) heal_pend_d = 1'b1;
      end

      invuln_d = (cool_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         upd_q       <= UPD_MOVE;
         len_q       <= '0;
         cool_q      <= '0;
         invuln_q    <= 1'b0;
         over_q      <= 1'b0;
         hit_pend_q  <= 1'b0;
         heal_pend_q <= 1'b0;
         hit_r_q     <= 1'b0;
         heal_r_q    <= 1'b0;
         vs_r_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         upd_q       <= upd_d;
         len_q       <= len_d;
         cool_q      <= cool_d;
         invuln_q    <= invuln_d;
         over_q      <= over_d;
         hit_pend_q  <= hit_pend_d;
         heal_pend_q <= heal_pend_d;
         hit_r_q     <= hit_req;
         heal_r_q    <= heal_req;
         vs_r_q      <= vsync;
      end
   end

   assign lengthUpdate = upd_q;
   assign length       = len_q;
   assign invuln       = invuln_q;
   assign game_over    = over_q;

endmodule

// File: tb/tb_dragon_length_ctrl.sv
// Randomized bench for dragon_length_ctrl against an event-level
// model of length, cooldown frames and game-over.
module tb_dragon_length_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vsync = 1'b0;
   logic       hit_req = 1'b0;
   logic       heal_req = 1'b0;
   logic [1:0] lengthUpdate;
   logic [2:0] length;
   logic       invuln;
   logic       game_over;

   int errors = 0;
   int checks = 0;

   int m_len  = 0;
   int m_cool = 0;
   bit m_dead = 0;

   dragon_length_ctrl #(
      .MAX_LEN(7),
      .HIT_COOLDOWN_FRAMES(60)
   ) dut (
      .clk(clk),
      .reset(reset),
      .vsync(vsync),
      .hit_req(hit_req),
      .heal_req(heal_req),
      .lengthUpdate(lengthUpdate),
      .length(length),
      .invuln(invuln),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".len"}, int'(length), m_len);
      chk({tag, ".inv"}, int'(invuln), int'(m_cool != 0));
      chk({tag, ".over"}, int'(game_over), int'(m_dead));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      hit_req = 1'b0;
      heal_req = 1'b0;
      vsync = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_len = 0;
      m_cool = 0;
      m_dead = 0;
      chk("rst.upd", int'(lengthUpdate), 0);
      chk_state("rst");
   endtask

   // Raise the chosen requests for hold clocks; the pulse must show
   // up exactly one clock after the first sampling edge and nowhere else.
   task automatic drive_evt(input bit h, input bit g, input int hold);
      int exp_upd;
      exp_upd = 0;
      if (h && !m_dead && m_cool == 0) begin
         if (m_len > 0) begin
            exp_upd = 2;
            m_len--;
            m_cool = 60;
         end else begin
            m_dead = 1;
         end
      end else if (g && !m_dead && m_len < 7) begin
         exp_upd = 1;
         m_len++;
      end
      @(negedge clk);
      hit_req = h;
      heal_req = g;
      for (int k = 0; k <= hold + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("evt.upd%0d", k), int'(lengthUpdate),
             (k == 1) ? exp_upd : 0);
         if (k == 1) chk_state("evt");
         if (k == hold - 1) begin
            hit_req = 1'b0;
            heal_req = 1'b0;
         end
      end
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vsync = 1'b1;
         repeat (2) @(negedge clk);
         vsync = 1'b0;
         repeat (2) @(negedge clk);
         if (m_cool > 0) m_cool--;
      end
      chk("frm.inv", int'(invuln), int'(m_cool != 0));
      chk("frm.upd", int'(lengthUpdate), 0);
   endtask

   initial begin
      int r;
      do_reset();

      drive_evt(1'b0, 1'b1, 5);

      do_reset();
      for (int i = 0; i < 8; i++) drive_evt(1'b0, 1'b1, 2);
      chk("sat.len", int'(length), 7);

      do_reset();
      for (int i = 0; i < 3; i++) drive_evt(1'b0, 1'b1, 2);
      drive_evt(1'b1, 1'b0, 2);
      chk("hit1.len", int'(length), 2);
      chk("hit1.inv", int'(invuln), 1);
      frames(30);
      drive_evt(1'b1, 1'b0, 2);
      frames(30);
      chk("cool.inv", int'(invuln), 0);
      drive_evt(1'b1, 1'b0, 2);
      chk("hit2.len", int'(length), 1);

      do_reset();
      drive_evt(1'b0, 1'b1, 2);
      drive_evt(1'b0, 1'b1, 2);
      drive_evt(1'b1, 1'b1, 2);
      chk("both.len", int'(length), 1);

      do_reset();
      drive_evt(1'b1, 1'b0, 2);
      chk("dead.over", int'(game_over), 1);
      drive_evt(1'b0, 1'b1, 2);
      drive_evt(1'b0, 1'b1, 3);
      do_reset();

      for (int it = 0; it < 80; it++) begin
         r = int'($urandom_range(0, 9));
         if (m_dead && $urandom_range(0, 1) == 1) r = 9;
         if (r <= 3) drive_evt(1'b0, 1'b1, int'($urandom_range(2, 4)));
         else if (r <= 5) drive_evt(1'b1, 1'b0, int'($urandom_range(2, 4)));
         else if (r == 6) drive_evt(1'b1, 1'b1, 2);
         else if (r <= 8) frames(int'($urandom_range(1, 40)));
         else do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
